tile_out_capture: RTL and testbench

TILE_OUT_CAPTURE -- requirements
Module: tile_out_capture

---
 rtl/tile_cap_pkg.sv | 20 ++
 rtl/tile_cap_fifo.sv | 83 ++++++++
 rtl/tile_out_capture.sv | 125 ++++++++++++
 tb/tb_tile_out_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_cap_pkg.sv
// Shared types and parameter defaults for the tile output capture block.
package tile_cap_pkg;

    localparam int DEPTH_DEF      = 4;
    localparam int TS_W_DEF       = 16;
    localparam int STABLE_CYC_DEF = 2;

    typedef enum logic {
        FLT_IDLE    = 1'b0,
        FLT_QUALIFY = 1'b1
    } flt_state_t;

    // Layout of one captured event at the default timestamp width; the FIFO
    // stores entries packed in this same {value, ts} order.
    typedef struct packed {
        logic [7:0]          value;
        logic [TS_W_DEF-1:0] ts;
    } tile_event_t;

endpackage

// File: rtl/tile_cap_fifo.sv
// Event FIFO with a combinational head, simultaneous push/pop when full and a sticky drop flag.
module tile_cap_fifo
    import tile_cap_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 8 + TS_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    input  logic         clear_ovf,
    output logic         valid,
    output logic [W-1:0] head_data,
    output logic         overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          overflow_reg;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);
    assign do_pop  = ready && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            // A drop wins over a same-cycle clear so no lost event goes unreported.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign valid     = !empty;
    assign head_data = empty ? '0 : mem[rd_ptr_reg];
    assign overflow  = overflow_reg;

endmodule

// File: rtl/tile_out_capture.sv
// Synchronizes and debounces a microtile output bus, timestamps each accepted change and queues it.
module tile_out_capture
    import tile_cap_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      uo_out_i,
    input  logic            arm,
    output logic [7:0]      level,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [7:0]      ev_data,
    output logic [TS_W-1:0] ev_ts,
    output logic            overflow,
    input  logic            clear_ovf
);

    localparam int EV_W = 8 + TS_W;
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYC - 1);

    logic [7:0]      s1_reg;
    logic [7:0]      s2_reg;
    logic [7:0]      level_reg;
    logic [7:0]      level_next;
    logic [7:0]      cand_reg;
    logic [7:0]      cand_next;
    logic [3:0]      cnt_reg;
    logic [3:0]      cnt_next;
    flt_state_t      state_reg;
    flt_state_t      state_next;
    logic [TS_W-1:0] ts_reg;
    logic            update;
    logic            push;
    logic [EV_W-1:0] push_data;
    logic [EV_W-1:0] head_data;

    // cnt holds how many consecutive samples have already matched the candidate;
    // the current sample completes qualification when cnt reaches STABLE_CYC-1.
    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        update     = 1'b0;
        case (state_reg)
            FLT_IDLE: begin
                if (s2_reg != level_reg) begin
                    if (STABLE_CYC == 1) begin
                        level_next = s2_reg;
                        update     = 1'b1;
                    end else begin
                        cand_next  = s2_reg;
                        cnt_next   = 4'd1;
                        state_next = FLT_QUALIFY;
                    end
                end
            end
            FLT_QUALIFY: begin
                if (s2_reg != cand_reg) begin
                    if (s2_reg != level_reg) begin
                        cand_next = s2_reg;
                        cnt_next  = 4'd1;
                    end else begin
                        state_next = FLT_IDLE;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    level_next = cand_reg;
                    update     = 1'b1;
                    state_next = FLT_IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = FLT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg    <= 8'h00;
            s2_reg    <= 8'h00;
            level_reg <= 8'h00;
            cand_reg  <= 8'h00;
            cnt_reg   <= 4'd0;
            state_reg <= FLT_IDLE;
            ts_reg    <= '0;
        end else begin
            s1_reg    <= uo_out_i;
            s2_reg    <= s1_reg;
            level_reg <= level_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            state_reg <= state_next;
            ts_reg    <= ts_reg + TS_W'(1);
        end
    end

    // The timestamp is the counter value seen on the edge that moves level.
    assign push      = update && arm;
    assign push_data = {level_next, ts_reg};

    tile_cap_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready     (ev_ready),
        .clear_ovf (clear_ovf),
        .valid     (ev_valid),
        .head_data (head_data),
        .overflow  (overflow)
    );

    assign level   = level_reg;
    assign ev_data = head_data[EV_W-1:TS_W];
    assign ev_ts   = head_data[TS_W-1:0];

endmodule

// File: tb/tb_tile_out_capture.sv
// Directed bench for tile_out_capture: filter timing, glitch rejection, FIFO limits, reset and timestamp wrap.
module tb_tile_out_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  uo_out_i = 8'h00;
    logic        arm = 1'b0;
    logic [7:0]  level;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [7:0]  ev_data;
    logic [15:0] ev_ts;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    logic [7:0]  uo2 = 8'h00;
    logic        arm2 = 1'b0;
    logic [7:0]  level2;
    logic        ev_valid2;
    logic        ev_ready2 = 1'b0;
    logic [7:0]  ev_data2;
    logic [3:0]  ev_ts2;
    logic        overflow2;
    logic        clear_ovf2 = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_out_capture dut (
        .clk       (clk),
        .rst       (rst),
        .uo_out_i  (uo_out_i),
        .arm       (arm),
        .level     (level),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_data   (ev_data),
        .ev_ts     (ev_ts),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    tile_out_capture #(.DEPTH(4), .TS_W(4), .STABLE_CYC(2)) dut_ts4 (
        .clk       (clk),
        .rst       (rst),
        .uo_out_i  (uo2),
        .arm       (arm2),
        .level     (level2),
        .ev_valid  (ev_valid2),
        .ev_ready  (ev_ready2),
        .ev_data   (ev_data2),
        .ev_ts     (ev_ts2),
        .overflow  (overflow2),
        .clear_ovf (clear_ovf2)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves rst low at a falling edge; the next rising edge sees ts == 0.
    task automatic do_reset();
        rst = 1'b1; uo_out_i = 8'h00; uo2 = 8'h00;
        arm = 1'b0; ev_ready = 1'b0; clear_ovf = 1'b0;
        arm2 = 1'b0; ev_ready2 = 1'b0; clear_ovf2 = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (level !== 8'h00) begin bad++; $display("FAIL rst_level: got %h want 00", level); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
        total++; if (ev_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", ev_data); end
        total++; if (ev_ts !== 16'h0000) begin bad++; $display("FAIL rst_ts: got %h want 0000", ev_ts); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_single_event();
        do_reset();
        arm = 1'b1; ev_ready = 1'b1;
        tick(); tick();
        uo_out_i = 8'hA5;
        tick(); tick(); tick();
        total++; if (level !== 8'h00) begin bad++; $display("FAIL a5_early_level: got %h want 00", level); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL a5_early_valid: got %b want 0", ev_valid); end
        tick();
        total++; if (level !== 8'hA5) begin bad++; $display("FAIL a5_level: got %h want a5", level); end
        total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL a5_valid: got %b want 1", ev_valid); end
        total++; if (ev_data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", ev_data); end
        total++; if (ev_ts !== 16'd5) begin bad++; $display("FAIL a5_ts: got %0d want 5", ev_ts); end
        tick();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL a5_popped: got %b want 0", ev_valid); end
        tick(); tick(); tick();
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL a5_single: got %b want 0", ev_valid); end
        $display("test_single_event: level=%h", level);
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        do_reset();
        arm = 1'b1; ev_ready = 1'b1;
        uo_out_i = 8'h3C;
        tick();
        uo_out_i = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ev_valid !== 1'b0 || level !== 8'h00) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_any: got %b want 0", seen); end
        total++; if (level !== 8'h00) begin bad++; $display("FAIL glitch_level: got %h want 00", level); end
        $display("test_glitch: level=%h", level);
    endtask

    task automatic test_overflow();
        logic [7:0] want;
        do_reset();
        arm = 1'b1; ev_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            uo_out_i = 8'(v);
            repeat (5) tick();
        end
        total++; if (level !== 8'h05) begin bad++; $display("FAIL ovf_level: got %h want 05", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        ev_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            want = 8'(i);
            total++; if (ev_valid !== 1'b1 || ev_data !== want) begin bad++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, ev_valid, ev_data, want); end
            tick();
        end
        ev_ready = 1'b0;
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", ev_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        $display("test_overflow: overflow=%b", overflow);
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        do_reset();
        arm = 1'b1; ev_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            uo_out_i = 8'(v);
            repeat (5) tick();
        end
        uo_out_i = 8'h05;
        tick(); tick(); tick();
        ev_ready = 1'b1;
        total++; if (ev_data !== 8'h01) begin bad++; $display("FAIL b2b_head: got %h want 01", ev_data); end
        tick();
        ev_ready = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
        total++; if (level !== 8'h05) begin bad++; $display("FAIL b2b_level: got %h want 05", level); end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want = 8'(i + 2);
            total++; if (ev_valid !== 1'b1 || ev_data !== want) begin bad++; $display("FAIL b2b_drain%0d: got v=%b d=%h want v=1 d=%h", i, ev_valid, ev_data, want); end
            tick();
        end
        ev_ready = 1'b0;
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL b2b_count: got %b want 0", ev_valid); end
        $display("test_back_to_back: overflow=%b", overflow);
    endtask

    task automatic test_no_arm();
        do_reset();
        arm = 1'b0; ev_ready = 1'b0;
        uo_out_i = 8'h7E;
        repeat (6) tick();
        total++; if (level !== 8'h7E) begin bad++; $display("FAIL noarm_level: got %h want 7e", level); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL noarm_valid: got %b want 0", ev_valid); end
        $display("test_no_arm: level=%h", level);
    endtask

    task automatic test_reset_mid();
        do_reset();
        arm = 1'b1; ev_ready = 1'b0;
        uo_out_i = 8'h11; repeat (5) tick();
        uo_out_i = 8'h22; repeat (5) tick();
        total++; if (ev_valid !== 1'b1 || ev_data !== 8'h11) begin bad++; $display("FAIL mid_queued: got v=%b d=%h want v=1 d=11", ev_valid, ev_data); end
        uo_out_i = 8'h33;
        tick(); tick(); tick();
        total++; if (level !== 8'h22) begin bad++; $display("FAIL mid_qualify: got %h want 22", level); end
        rst = 1'b1; uo_out_i = 8'h00;
        tick();
        total++; if (level !== 8'h00) begin bad++; $display("FAIL mid_rst_level: got %h want 00", level); end
        total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", ev_valid); end
        total++; if (ev_data !== 8'h00 || ev_ts !== 16'h0000) begin bad++; $display("FAIL mid_rst_head: got %h/%h want 00/0000", ev_data, ev_ts); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
        rst = 1'b0;
        repeat (8) tick();
        total++; if (ev_valid !== 1'b0 || level !== 8'h00) begin bad++; $display("FAIL mid_stale: got v=%b l=%h want v=0 l=00", ev_valid, level); end
        $display("test_reset_mid: level=%h", level);
    endtask

    task automatic test_ts_wrap();
        do_reset();
        arm2 = 1'b1; ev_ready2 = 1'b0;
        repeat (12) tick();
        uo2 = 8'h09;
        tick(); tick(); tick();
        total++; if (ev_valid2 !== 1'b0) begin bad++; $display("FAIL wrap_early: got %b want 0", ev_valid2); end
        tick();
        total++; if (ev_valid2 !== 1'b1 || ev_data2 !== 8'h09) begin bad++; $display("FAIL wrap_ev15: got v=%b d=%h want v=1 d=09", ev_valid2, ev_data2); end
        total++; if (ev_ts2 !== 4'd15) begin bad++; $display("FAIL wrap_ts15: got %0d want 15", ev_ts2); end
        do_reset();
        arm2 = 1'b1; ev_ready2 = 1'b0;
        repeat (13) tick();
        uo2 = 8'h06;
        repeat (4) tick();
        total++; if (ev_valid2 !== 1'b1 || ev_data2 !== 8'h06) begin bad++; $display("FAIL wrap_ev0: got v=%b d=%h want v=1 d=06", ev_valid2, ev_data2); end
        total++; if (ev_ts2 !== 4'd0) begin bad++; $display("FAIL wrap_ts0: got %0d want 0", ev_ts2); end
        $display("test_ts_wrap: ts=%0d", ev_ts2);
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_no_arm();
        test_reset_mid();
        test_ts_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
